fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the FIFO write side (INC strobe plus write data) among N requesters.
- Grants one requester at a time for a bounded burst, stalls writes while FULL_FLAG is high and rotates priority after every burst.
- Sits between the sender-side clients and the FIFO write-pointer and memory logic, in the CLK write domain.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/rr_priority_enc.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, defaults and the round-robin search used by the FIFO write arbiter.
package fifo_pkg;

  typedef enum logic {IDLE, BURST} state_t;

  localparam int unsigned DEFAULT_DW        = 8;
  localparam int unsigned DEFAULT_N         = 4;
  localparam int unsigned DEFAULT_MAX_BURST = 4;

  localparam int unsigned MAX_N  = 8;
  localparam int unsigned MAX_PW = 3;

  typedef struct packed {
    logic              valid;
    logic [MAX_PW-1:0] idx;
  } rr_pick_t;

  // First set bit of req searching upward from ptr, wrapping modulo n (n <= MAX_N).
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input logic [MAX_PW-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !res.valid && req[idx[MAX_PW-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = idx[MAX_PW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Combinational round-robin search over N requests starting at the priority pointer.
module rr_priority_enc
  import fifo_pkg::*;
#(
  parameter  int unsigned N  = DEFAULT_N,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid_c,
  output logic [PW-1:0] o_idx_c
);

  logic [MAX_N-1:0] w_req;
  rr_pick_t         w_pick;

  assign w_req     = MAX_N'(i_req);
  assign w_pick    = rr_pick(w_req, MAX_PW'(i_ptr), N);
  assign o_valid_c = w_pick.valid;
  assign o_idx_c   = PW'(w_pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N requesters in bounded bursts.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int unsigned N         = DEFAULT_N,
  parameter  int unsigned DW        = DEFAULT_DW,
  parameter  int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  localparam int unsigned PW        = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  REQ,
  input  logic [N*DW-1:0] DIN,
  input  logic          FULL_FLAG,
  output logic [N-1:0]  GNT,
  output logic [N-1:0]  ACK,
  output logic          INC,
  output logic [DW-1:0] WDATA,
  output logic [PW-1:0] OWNER,
  output logic          BUSY
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  logic          w_valid;
  logic [PW-1:0] w_idx;
  logic          w_own_req;
  logic [PW-1:0] w_next_ptr;

  rr_priority_enc #(.N(N)) u_rr (
    .i_req     (REQ),
    .i_ptr     (r_ptr),
    .o_valid_c (w_valid),
    .o_idx_c   (w_idx)
  );

  assign GNT        = r_gnt;
  assign OWNER      = r_owner;
  assign BUSY       = (r_state == BURST);
  assign ACK        = r_gnt & REQ & {N{~FULL_FLAG}};
  assign INC        = |ACK;
  assign w_own_req  = |(r_gnt & REQ);
  assign w_next_ptr = (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);

  // One-hot grant makes the data mux a masked OR of the requester lanes.
  always_comb begin
    WDATA = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_gnt[i]) WDATA = WDATA | DIN[i*DW +: DW];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= N'(1) << w_idx;
            r_owner <= w_idx;
            r_cnt   <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          // Release by the owner wins over any stall; a full-count write also closes the burst.
          if (!w_own_req) begin
            r_gnt   <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
          end else if (INC) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(MAX_BURST - 1)) begin
              r_gnt   <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a burst-level behavioural model.
module tb_fifo_wr_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ_A, GNT_A, ACK_A;
  logic [31:0] DIN_A;
  logic        FULL_A, INC_A, BUSY_A;
  logic [7:0]  WDATA_A;
  logic [1:0]  OWNER_A;
  logic [2:0]  REQ_B, GNT_B, ACK_B;
  logic [23:0] DIN_B;
  logic        FULL_B, INC_B, BUSY_B;
  logic [7:0]  WDATA_B;
  logic [1:0]  OWNER_B;

  fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4)) dut_a (
    .CLK(CLK), .RST(RST), .REQ(REQ_A), .DIN(DIN_A), .FULL_FLAG(FULL_A),
    .GNT(GNT_A), .ACK(ACK_A), .INC(INC_A), .WDATA(WDATA_A), .OWNER(OWNER_A), .BUSY(BUSY_A)
  );

  fifo_wr_arbiter #(.N(3), .DW(8), .MAX_BURST(1)) dut_b (
    .CLK(CLK), .RST(RST), .REQ(REQ_B), .DIN(DIN_B), .FULL_FLAG(FULL_B),
    .GNT(GNT_B), .ACK(ACK_B), .INC(INC_B), .WDATA(WDATA_B), .OWNER(OWNER_B), .BUSY(BUSY_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model: who holds the port (-1 = nobody), writes in this burst, pointer, last grantee.
  int m_owner, m_cnt, m_ptr, m_last;
  int pend[4];
  int seq[4];
  logic full;
  logic [28:0] e_a, o_a;

  task automatic m_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
  endtask

  // Packed expectation: {gnt[8], ack[8], inc, wdata[8], owner[3], busy}.
  function automatic logic [28:0] m_exp(input logic [7:0] req, input logic fl, input logic [63:0] din);
    logic [7:0] g, a, wd;
    g = '0; wd = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      wd = din[m_owner*8 +: 8];
    end
    a = g & req & {8{~fl}};
    return {g, a, |a, wd, 3'(m_last), m_owner >= 0};
  endfunction

  task automatic m_step(input int n, input int mb, input logic [7:0] req, input logic fl);
    logic found;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < n; k++) begin
        if (!found && req[(m_ptr + k) % n]) begin
          found = 1'b1; m_owner = (m_ptr + k) % n; m_last = m_owner; m_cnt = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % n; m_owner = -1;
    end else if (!fl) begin
      m_cnt++;
      if (m_cnt == mb) begin
        m_ptr = (m_owner + 1) % n; m_owner = -1;
      end
    end
  endtask

  task automatic a_eval();
    for (int i = 0; i < 4; i++) begin
      REQ_A[i] = pend[i] > 0;
      DIN_A[i*8 +: 8] = 8'(i*64 + (seq[i] + 1)*17);
    end
    FULL_A = full;
    #1;
    e_a = m_exp(8'(REQ_A), FULL_A, 64'(DIN_A));
    o_a = {8'(GNT_A), 8'(ACK_A), INC_A, WDATA_A, 3'(OWNER_A), BUSY_A};
  endtask

  task automatic a_clk();
    for (int i = 0; i < 4; i++) begin
      if (e_a[13+i]) begin pend[i]--; seq[i]++; end
    end
    m_step(4, 4, 8'(REQ_A), FULL_A);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; full = 1'b0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; seq[i] = 0; end
    REQ_A = '0; DIN_A = '0; FULL_A = 1'b0;
    REQ_B = '0; DIN_B = '0; FULL_B = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; REQ_A = 4'hF; DIN_A = $urandom; FULL_A = 1'b0;
    REQ_B = 3'h7; DIN_B = 24'($urandom); FULL_B = 1'b0;
    @(posedge CLK); #2;
    checks++;
    if ({GNT_A, ACK_A, INC_A, WDATA_A, OWNER_A, BUSY_A} !== '0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {GNT_A, ACK_A, INC_A, WDATA_A, OWNER_A, BUSY_A});
    end
    checks++;
    if ({GNT_B, ACK_B, INC_B, WDATA_B, OWNER_B, BUSY_B} !== '0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", {GNT_B, ACK_B, INC_B, WDATA_B, OWNER_B, BUSY_B});
    end
    do_reset();
  endtask

  task automatic test_single();
    int wr_k[$];
    logic [7:0] wr_d[$];
    logic [7:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    pend[0] = 100;
    for (int k = 0; k < 8; k++) begin
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL single cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (k < 6 && INC_A) begin wr_k.push_back(k); wr_d.push_back(WDATA_A); end
      if (k == 5) begin
        checks++;
        if (GNT_A !== 4'b0000) begin failures++; $display("FAIL single_bubble got=%b exp=0000", GNT_A); end
      end
      if (k == 6) begin
        checks++;
        if (GNT_A !== 4'b0001) begin failures++; $display("FAIL single_regrant got=%b exp=0001", GNT_A); end
      end
      a_clk();
    end
    checks++;
    if (wr_k.size() != 4) begin
      failures++; $display("FAIL single_count got=%0d exp=4", wr_k.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_k[i] != i + 1 || wr_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL single_write%0d got=cyc%0d/%h exp=cyc%0d/%h", i, wr_k[i], wr_d[i], i + 1, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_all_req();
    int owners[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    logic pb;
    do_reset();
    for (int i = 0; i < 4; i++) pend[i] = 100;
    pb = 1'b0;
    for (int k = 0; k < 30; k++) begin
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL all_req cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (BUSY_A && !pb) owners.push_back(int'(OWNER_A));
      pb = BUSY_A;
      a_clk();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (owners.size() <= i || owners[i] != exp_o[i]) begin
        failures++;
        $display("FAIL all_req_order idx=%0d got=%0d exp=%0d", i, (owners.size() > i) ? owners[i] : -1, exp_o[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    int wr, stall, stall_obs, inc_obs;
    do_reset();
    pend[2] = 4;
    wr = 0; stall = 0; stall_obs = 0; inc_obs = 0;
    for (int k = 0; k < 14; k++) begin
      full = (wr == 2 && stall < 5);
      if (full) stall++;
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL full_stall cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (GNT_A == 4'b0100 && !INC_A && ACK_A == 4'b0000) stall_obs++;
      if (INC_A) inc_obs++;
      if (e_a[12]) wr++;
      a_clk();
    end
    full = 1'b0;
    checks++;
    if (stall_obs != 5 || inc_obs != 4) begin
      failures++; $display("FAIL full_stall_totals got=stall%0d/wr%0d exp=stall5/wr4", stall_obs, inc_obs);
    end
  endtask

  task automatic test_release();
    int owners[$];
    int exp_o[3] = '{1, 3, 0};
    logic pb;
    do_reset();
    pend[1] = 2; pend[3] = 10;
    pb = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) pend[0] = 3;
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL release cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (BUSY_A && !pb) owners.push_back(int'(OWNER_A));
      pb = BUSY_A;
      a_clk();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (owners.size() <= i || owners[i] != exp_o[i]) begin
        failures++;
        $display("FAIL release_order idx=%0d got=%0d exp=%0d", i, (owners.size() > i) ? owners[i] : -1, exp_o[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pend[0] = 10;
    for (int k = 0; k < 4; k++) begin
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL async_pre cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (k < 3) a_clk();
    end
    #1 RST = 1'b0;
    #1;
    checks++;
    if ({GNT_A, ACK_A, INC_A, WDATA_A, OWNER_A, BUSY_A} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {GNT_A, ACK_A, INC_A, WDATA_A, OWNER_A, BUSY_A});
    end
    m_reset();
    for (int i = 0; i < 4; i++) begin pend[i] = 0; seq[i] = 0; end
    pend[2] = 3;
    @(posedge CLK); #1 RST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL async_post cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      if (k == 1) begin
        checks++;
        if (GNT_A !== 4'b0100 || OWNER_A !== 2'd2) begin
          failures++; $display("FAIL async_first_grant got=%b/%0d exp=0100/2", GNT_A, OWNER_A);
        end
      end
      a_clk();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = int'($urandom_range(1, 6));
      end
      full = ($urandom_range(0, 9) < 3);
      a_eval();
      checks++;
      if (o_a !== e_a) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", k, o_a, e_a); end
      a_clk();
    end
    full = 1'b0;
  endtask

  task automatic test_n3();
    logic [28:0] e_b, o_b;
    int owners[$];
    int exp_o[4] = '{0, 1, 2, 0};
    int sb[3];
    logic pb;
    do_reset();
    for (int i = 0; i < 3; i++) sb[i] = 0;
    pb = 1'b0;
    for (int k = 0; k < 12; k++) begin
      REQ_B = 3'b111;
      for (int i = 0; i < 3; i++) DIN_B[i*8 +: 8] = 8'(i*64 + sb[i] + 1);
      FULL_B = 1'b0;
      #1;
      e_b = m_exp(8'(REQ_B), FULL_B, 64'(DIN_B));
      o_b = {8'(GNT_B), 8'(ACK_B), INC_B, WDATA_B, 3'(OWNER_B), BUSY_B};
      checks++;
      if (o_b !== e_b) begin failures++; $display("FAIL n3 cyc=%0d got=%h exp=%h", k, o_b, e_b); end
      if (BUSY_B && !pb) owners.push_back(int'(OWNER_B));
      pb = BUSY_B;
      for (int i = 0; i < 3; i++) if (e_b[13+i]) sb[i]++;
      m_step(3, 1, 8'(REQ_B), FULL_B);
      @(posedge CLK); #1;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (owners.size() <= i || owners[i] != exp_o[i]) begin
        failures++;
        $display("FAIL n3_order idx=%0d got=%0d exp=%0d", i, (owners.size() > i) ? owners[i] : -1, exp_o[i]);
      end
    end
  endtask

  initial begin
    RST = 1'b0; full = 1'b0;
    REQ_A = '0; DIN_A = '0; FULL_A = 1'b0;
    REQ_B = '0; DIN_B = '0; FULL_B = 1'b0;
    m_reset();
    test_reset();
    test_single();
    test_all_req();
    test_full_stall();
    test_release();
    test_async_reset();
    test_random();
    test_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
